inst_fetch_unit: RTL and testbench

//   Decoupled instruction fetch stage that drives the PC into instruction memory.
//   It issues one request at a time over a req/ack handshake and buffers returned words with their PCs in a small queue.
//   It presents {inst, inst_pc} to decode over a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/inst_fetch_unit.sv | 94 +++++++++
 tb/tb_inst_fetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state, NOP encoding and queue entry layout for the fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    localparam logic [31:0] NOP_INST = 32'h00000013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous queue of fetched {pc, inst} entries with flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wptr] <= din;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: decoupled fetch stage with req/ack imem port, entry queue and redirect flush.
// Optional FETCH_PERF_EN adds push and redirect counters.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t        state;
    logic [31:0]   fetch_pc, target, next_pc;
    logic          push, pop, full, empty;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    assign target     = {redirect_pc[31:2], 2'b00};
    assign next_pc    = fetch_pc + 32'd4;
    assign push       = state == REQ && imem_ack && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign imem_req   = state != IDLE;
    assign inst_valid = !empty;
    assign inst       = empty ? NOP_INST : head.inst;
    assign inst_pc    = empty ? '0 : head.pc;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redirect_valid),
        .din  ('{pc: fetch_pc, inst: imem_rdata}),
        .head (head),
        .full (full),
        .empty(empty),
        .count(count)
    );
    // imem_addr only diverges from fetch_pc while draining a request orphaned by a redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= target;
            if (imem_req && !imem_ack) begin
                state <= DRAIN;
            end else begin
                state     <= REQ;
                imem_addr <= target;
            end
        end else begin
            case (state)
                IDLE: if (!full || pop) state <= REQ;
                REQ: if (imem_ack) begin
                    fetch_pc  <= next_pc;
                    imem_addr <= next_pc;
                    state     <= (count < CW'(DEPTH - 1) || pop) ? REQ : IDLE;
                end
                DRAIN: if (imem_ack) begin
                    state     <= REQ;
                    imem_addr <= fetch_pc;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios plus random traffic checked against a queue-based fetch model.
module tb_inst_fetch_unit;
    import fetch_pkg::*;
    localparam int DEPTH = 4;
    logic        clk = 0, rst = 0;
    logic        redirect_valid = 0, imem_ack = 0, inst_ready = 0;
    logic [31:0] redirect_pc = 0, imem_rdata = 0;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc;
    int          n_checks = 0, n_errors = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_flush_cnt;
`endif
    fetch_entry_t q[$];
    logic        m_busy, m_discard;
    logic [31:0] m_pc, m_addr, m_fetch;
    logic [15:0] m_flush;

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_discard = 0; m_pc = 0; m_addr = 0; m_fetch = 0; m_flush = 0;
    endtask

    // Called at posedge+1: compare outputs, drive inputs, advance one edge, update model.
    task automatic step(input logic rv, input logic [31:0] rp, input logic ak, input logic rd);
        logic ack, pop;
        logic [31:0] data, tgt;
        check("imem_req", imem_req, m_busy);
        if (m_busy) check("imem_addr", imem_addr, m_addr);
        check("inst_valid", inst_valid, q.size() != 0);
        check("inst", inst, q.size() != 0 ? q[0].inst : NOP_INST);
        check("inst_pc", inst_pc, q.size() != 0 ? q[0].pc : 32'h0);
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_flush", perf_flush_cnt, m_flush);
`endif
        ack  = ak && m_busy;
        data = $urandom;
        tgt  = rp & ~32'h3;
        redirect_valid = rv; redirect_pc = rp; imem_ack = ack; inst_ready = rd; imem_rdata = data;
        @(posedge clk);
        pop = q.size() != 0 && rd;
        if (rv) begin
            q.delete();
            if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
            m_pc = tgt;
            if (m_busy && !ack) m_discard = 1;
            else begin m_busy = 1; m_addr = tgt; m_discard = 0; end
        end else begin
            if (pop) void'(q.pop_front());
            if (m_busy && ack) begin
                if (m_discard) begin
                    m_discard = 0; m_addr = m_pc;
                end else begin
                    q.push_back(fetch_entry_t'{pc: m_addr, inst: data});
                    m_fetch = m_fetch + 32'd1;
                    m_pc = m_addr + 32'd4; m_addr = m_pc;
                    m_busy = q.size() < DEPTH;
                end
            end else if (!m_busy && q.size() < DEPTH) begin
                m_busy = 1; m_addr = m_pc;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 0; redirect_valid = 0; imem_ack = 0; inst_ready = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_inst", inst, NOP_INST);
        // 1: ack every cycle, consume every cycle
        step(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            check("t1_addr", imem_addr, 32'(i * 4));
            if (i > 0) check("t1_pc", inst_pc, 32'((i - 1) * 4));
            step(0, 0, 1, 1);
        end
        // 2: decode stalled, queue fills, one pop reopens one slot
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        check("t2_req", imem_req, 1'b0);
        check("t2_pc", inst_pc, 32'h0);
        step(0, 0, 0, 1);
        check("t2_resume_req", imem_req, 1'b1);
        check("t2_resume_addr", imem_addr, 32'h10);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("t2_single", imem_req, 1'b0);
        // 3: redirect while request at 0x8 outstanding
        do_reset();
        step(0, 0, 0, 1); step(0, 0, 1, 1); step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(1, 32'h103, 0, 1);
        check("t3_drain_addr", imem_addr, 32'h8);
        check("t3_drain_valid", inst_valid, 1'b0);
        step(0, 0, 0, 1); step(0, 0, 1, 1);
        check("t3_new_addr", imem_addr, 32'h100);
        step(0, 0, 1, 0);
        check("t3_first_pc", inst_pc, 32'h100);
        // 4: redirect coinciding with pop and ack
        do_reset();
        step(0, 0, 0, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(1, 32'h200, 1, 1);
        check("t4_flush", inst_valid, 1'b0);
        check("t4_addr", imem_addr, 32'h200);
        step(0, 0, 1, 0);
        check("t4_pc", inst_pc, 32'h200);
        // 5: address wrap
        do_reset();
        step(0, 0, 0, 0);
        step(1, 32'hFFFFFFFE, 1, 0);
        check("t5_addr0", imem_addr, 32'hFFFFFFFC);
        step(0, 0, 1, 0);
        check("t5_addr1", imem_addr, 32'h0);
        check("t5_pc", inst_pc, 32'hFFFFFFFC);
        // 6: async reset mid-DRAIN
        step(0, 0, 1, 0);
        step(1, 32'h40, 0, 0);
        check("t6_drain_addr", imem_addr, 32'h4);
        #2 rst = 0;
        #1;
        check("t6_req", imem_req, 1'b0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_valid", inst_valid, 1'b0);
        check("t6_inst", inst, NOP_INST);
        check("t6_pc", inst_pc, 32'h0);
`ifdef FETCH_PERF_EN
        check("t6_perf_fetch", perf_fetch_cnt, 32'h0);
        check("t6_perf_flush", {16'h0, perf_flush_cnt}, 32'h0);
`endif
        redirect_valid = 0; imem_ack = 0;
        @(posedge clk); #1;
        rst = 1;
        model_reset();
        step(0, 0, 0, 0);
        check("t6_first_addr", imem_addr, 32'h0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom % 16) == 0, $urandom, ($urandom % 2) == 0, ($urandom % 10) < 7);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
